// File: rtl/alu_pkg.sv
// Shared widths and opcode encodings for the shared-ALU arbiter and its arithmetic core.
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int OP_W    = 5;
  localparam int SHAMT_W = 5;

  localparam logic [OP_W-1:0] OP_ADD = 5'b00000;
  localparam logic [OP_W-1:0] OP_SUB = 5'b00001;
  localparam logic [OP_W-1:0] OP_AND = 5'b00010;
  localparam logic [OP_W-1:0] OP_OR  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SLL = 5'b00100;
  localparam logic [OP_W-1:0] OP_SRA = 5'b00101;

endpackage

// File: rtl/alu_core.sv
// Purely combinational integer ALU: (op, a, b, shamt) -> (result, signed overflow).
module alu_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   result,
  output logic               ovf
);

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] sum_s;

  // Operand conditioning and result selection
  always_comb begin
    b_eff_s = b;
    if (op == OP_SUB) begin
      b_eff_s = ~b + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      b_eff_s = b;
    end
    sum_s  = a + b_eff_s;
    result = {WIDTH{1'b0}};
    ovf    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result = sum_s;
        // Overflow: both addends share a sign that the sum does not
        ovf    = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLL:  result = a << shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      default: begin
        result = {WIDTH{1'b0}};
        ovf    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute stage (req0) and the plotter
// coordinate unit (req1), returning results through a single registered, id-tagged slot.
module alu_share_arbiter
  import alu_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [OP_W-1:0]    req0_op,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [OP_W-1:0]    req1_op,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_ovf
);

  logic               accept_s;
  logic               both_s;
  logic               gnt_valid_s;
  logic               gnt_id_s;
  logic               rr_ptr_r;
  logic [OP_W-1:0]    op_s;
  logic [WIDTH-1:0]   a_s;
  logic [WIDTH-1:0]   b_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic [WIDTH-1:0]   alu_result_s;
  logic               alu_ovf_s;
  logic               rsp_valid_r;
  logic               rsp_id_r;
  logic [WIDTH-1:0]   rsp_result_r;
  logic               rsp_ovf_r;

  // Slot availability and grant decision; readys stay low while reset is held
  always_comb begin
    accept_s    = reset && (!rsp_valid_r || rsp_ready);
    both_s      = req0_valid && req1_valid;
    gnt_valid_s = req0_valid || req1_valid;
    if (both_s) begin
      gnt_id_s = rr_ptr_r;
    end else if (req1_valid) begin
      gnt_id_s = 1'b1;
    end else begin
      gnt_id_s = 1'b0;
    end
    req0_ready = accept_s && gnt_valid_s && !gnt_id_s;
    req1_ready = accept_s && gnt_valid_s && gnt_id_s;
  end

  // Operand mux in front of the single ALU instance
  always_comb begin
    if (gnt_id_s) begin
      op_s    = req1_op;
      a_s     = req1_a;
      b_s     = req1_b;
      shamt_s = req1_shamt;
    end else begin
      op_s    = req0_op;
      a_s     = req0_a;
      b_s     = req0_b;
      shamt_s = req0_shamt;
    end
  end

  alu_core u_alu_core (
    .op     (op_s),
    .a      (a_s),
    .b      (b_s),
    .shamt  (shamt_s),
    .result (alu_result_s),
    .ovf    (alu_ovf_s)
  );

  // Response slot and round-robin pointer; a stall leaves everything untouched
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= {WIDTH{1'b0}};
      rsp_ovf_r    <= 1'b0;
      rr_ptr_r     <= 1'b0;
    end else if (accept_s) begin
      if (gnt_valid_s) begin
        rsp_valid_r  <= 1'b1;
        rsp_id_r     <= gnt_id_s;
        rsp_result_r <= alu_result_s;
        rsp_ovf_r    <= alu_ovf_s;
      end else begin
        rsp_valid_r  <= 1'b0;
      end
      // Only contested grants move the pointer, toward the side that lost
      if (both_s) begin
        rr_ptr_r <= ~gnt_id_s;
      end
    end
  end

  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_ovf    = rsp_ovf_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               req0_valid, req1_valid, rsp_ready;
  logic               req0_ready, req1_ready;
  logic [OP_W-1:0]    req0_op, req1_op;
  logic [WIDTH-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic [SHAMT_W-1:0] req0_shamt, req1_shamt;
  logic               rsp_valid, rsp_id, rsp_ovf;
  logic [WIDTH-1:0]   rsp_result;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_rr;
  bit          m_vld;
  bit          m_id;
  logic [31:0] m_res;
  bit          m_ovf;
  bit          m_acc;
  bit          m_in_reset;
  int          exp_grant;
  bit          exp_rdy0, exp_rdy1;

  always #5 clock = ~clock;

  alu_share_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_ovf(rsp_ovf)
  );

  // Arithmetic reference using wide signed math and bit-by-bit shifting
  function automatic void ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] r, output bit o);
    longint      sa, sb, s;
    logic [31:0] bn;
    r = 32'd0;
    o = 1'b0;
    case (op)
      5'd0, 5'd1: begin
        bn = (op == 5'd1) ? (~b + 32'd1) : b;
        sa = longint'($signed(a));
        sb = longint'($signed(bn));
        s  = sa + sb;
        r  = s[31:0];
        o  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a * (32'd1 << sh);
      5'd5: begin
        r = a;
        for (int i = 0; i < int'(sh); i++) r = {r[31], r[31:1]};
      end
      default: begin r = 32'd0; o = 1'b0; end
    endcase
  endfunction

  task automatic model_reset();
    m_rr = 0; m_vld = 1'b0; m_id = 1'b0; m_res = 32'd0; m_ovf = 1'b0;
  endtask

  task automatic calc_expect();
    m_acc = !m_in_reset && (!m_vld || rsp_ready);
    exp_grant = -1;
    if (m_acc) begin
      if (req0_valid && req1_valid) exp_grant = m_rr;
      else if (req0_valid) exp_grant = 0;
      else if (req1_valid) exp_grant = 1;
    end
    exp_rdy0 = (exp_grant == 0);
    exp_rdy1 = (exp_grant == 1);
  endtask

  // Advance one clock and update the model with the transaction that happened
  task automatic tick();
    logic [31:0] r;
    bit          o;
    calc_expect();
    if (exp_grant == 0) ref_alu(req0_op, req0_a, req0_b, req0_shamt, r, o);
    else                ref_alu(req1_op, req1_a, req1_b, req1_shamt, r, o);
    @(posedge clock);
    if (m_acc) begin
      if (exp_grant >= 0) begin
        m_vld = 1'b1; m_id = exp_grant[0]; m_res = r; m_ovf = o;
      end else begin
        m_vld = 1'b0;
      end
      if (req0_valid && req1_valid) m_rr = 1 - exp_grant;
    end
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_op = 5'd0; req0_a = 32'd0; req0_b = 32'd0; req0_shamt = 5'd0;
    req1_op = 5'd0; req1_a = 32'd0; req1_b = 32'd0; req1_shamt = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0; m_in_reset = 1'b1; model_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b0 || rsp_result !== 32'd0 || rsp_id !== 1'b0 || rsp_ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rsp: got v=%b res=%h id=%b ovf=%b want 0/0/0/0", rsp_valid, rsp_result, rsp_id, rsp_ovf);
      end
    end
    idle_inputs();
    #2 reset = 1'b1; m_in_reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    idle_inputs();
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd7; req0_b = 32'd5;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd12 || rsp_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL single_rsp: got v=%b id=%b res=%0d ovf=%b want 1/0/12/0", rsp_valid, rsp_id, rsp_result, rsp_ovf);
    end
    tick();
  endtask

  task automatic test_contention();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_op = 5'($urandom_range(0, 5)); req0_a = $urandom; req0_b = $urandom;
      req0_shamt = 5'($urandom);
      req1_valid = 1'b1; req1_op = 5'($urandom_range(0, 5)); req1_a = $urandom; req1_b = $urandom;
      req1_shamt = 5'($urandom);
      #1;
      n_checks++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        n_fail++; $display("FAIL contention_order[%0d]: got %b%b want grant %0d", i, req0_ready, req1_ready, i % 2);
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== m_id || rsp_result !== m_res || rsp_ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL contention_rsp[%0d]: got v=%b id=%b res=%h ovf=%b want 1/%b/%h/%b",
                 i, rsp_valid, rsp_id, rsp_result, rsp_ovf, m_id, m_res, m_ovf);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    req1_valid = 1'b1; req1_op = OP_OR; req1_a = 32'hF0; req1_b = 32'h0F;
    tick();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = OP_SUB; req0_a = 32'd100; req0_b = 32'd1;
    req1_op = OP_ADD; req1_a = 32'd1; req1_b = 32'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready[%0d]: got %b%b want 00", i, req0_ready, req1_ready);
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'hFF || rsp_id !== 1'b1 || rsp_ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b res=%h id=%b want 1/000000ff/1", i, rsp_valid, rsp_result, rsp_id);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_release_grant: got %b%b want 10", req0_ready, req1_ready);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd99) begin
      n_fail++; $display("FAIL bp_release_rsp: got v=%b id=%b res=%0d want 1/0/99", rsp_valid, rsp_id, rsp_result);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_corners();
    logic [4:0]  c_op[4]  = '{5'd0, 5'd1, 5'd5, 5'd31};
    logic [31:0] c_a[4]   = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h12345678};
    logic [31:0] c_b[4]   = '{32'd1, 32'd1, 32'd0, 32'h9ABCDEF0};
    logic [4:0]  c_sh[4]  = '{5'd0, 5'd0, 5'd31, 5'd3};
    logic [31:0] c_res[4] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0};
    bit          c_ovf[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_op = c_op[i]; req0_a = c_a[i]; req0_b = c_b[i]; req0_shamt = c_sh[i];
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== c_res[i] || rsp_ovf !== c_ovf[i]) begin
        n_fail++;
        $display("FAIL corner[%0d]: got v=%b res=%h ovf=%b want 1/%h/%b", i, rsp_valid, rsp_result, rsp_ovf, c_res[i], c_ovf[i]);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    bit pend0 = 1'b0, pend1 = 1'b0;
    idle_inputs();
    for (int i = 0; i < 300; i++) begin
      if (!pend0) begin
        req0_valid = ($urandom_range(0, 3) != 0); req0_op = 5'($urandom_range(0, 7));
        req0_a = $urandom; req0_b = $urandom; req0_shamt = 5'($urandom);
      end
      if (!pend1) begin
        req1_valid = ($urandom_range(0, 3) != 0); req1_op = 5'($urandom_range(0, 7));
        req1_a = $urandom; req1_b = $urandom; req1_shamt = 5'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      calc_expect();
      n_checks++;
      if (req0_ready !== exp_rdy0 || req1_ready !== exp_rdy1) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b%b want %b%b", i, req0_ready, req1_ready, exp_rdy0, exp_rdy1);
      end
      pend0 = req0_valid && !exp_rdy0;
      pend1 = req1_valid && !exp_rdy1;
      tick();
      n_checks++;
      if (rsp_valid !== m_vld || (m_vld && (rsp_id !== m_id || rsp_result !== m_res || rsp_ovf !== m_ovf))) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d]: got v=%b id=%b res=%h ovf=%b want %b/%b/%h/%b",
                 i, rsp_valid, rsp_id, rsp_result, rsp_ovf, m_vld, m_id, m_res, m_ovf);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    req0_valid = 1'b1; req1_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd3; req0_b = 32'd4;
    req1_op = OP_AND; req1_a = 32'hFF; req1_b = 32'h0F;
    if (m_rr != 0) tick();
    tick();
    rsp_ready = 1'b0;
    tick();
    #2 reset = 1'b0; m_in_reset = 1'b1; model_reset();
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_drop: got rsp_valid=%b want 0", rsp_valid);
    end
    #2 reset = 1'b1; m_in_reset = 1'b0;
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_rrptr: got %b%b want 10", req0_ready, req1_ready);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd7) begin
      n_fail++; $display("FAIL async_reset_reissue: got v=%b id=%b res=%0d want 1/0/7", rsp_valid, rsp_id, rsp_result);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_corners();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
